uart_transceiver: RTL and testbench

- Full-duplex 8N1 UART datapath: a byte transmitter and a byte receiver sharing one clock, one reset and one oversampling enable.
- Sits between a bus/CPU interface (wr_tx/rd_rx handshakes) and the serial pins.
- An external baud-rate generator supplies en_16x, a one-clock pulse at 16x the baud rate.
- txd and rxd are independent, so a loopback txd->rxd is legal.

---
 rtl/uart_transceiver.sv | 210 +++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART datapath: byte transmitter and oversampling receiver sharing
// one clock, one reset and one en_16x tick.
module uart_transceiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_16x,
  input  logic       wr_tx,
  input  logic [7:0] wr_data,
  output logic       txd,
  output logic       tbr,
  input  logic       rxd,
  input  logic       rd_rx,
  output logic [7:0] rx_data,
  output logic       rda
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] TickLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] TickHalf = CntW'(OVERSAMPLE / 2 - 1);

  localparam logic [1:0] TxIdle  = 2'd0;
  localparam logic [1:0] TxStart = 2'd1;
  localparam logic [1:0] TxData  = 2'd2;
  localparam logic [1:0] TxStop  = 2'd3;

  localparam logic [2:0] RxIdle  = 3'd0;
  localparam logic [2:0] RxStart = 3'd1;
  localparam logic [2:0] RxData  = 3'd2;
  localparam logic [2:0] RxStop  = 3'd3;
  localparam logic [2:0] RxWait  = 3'd4;

  // Transmitter state
  logic [1:0]      tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;

  // Receiver state
  logic            rxd_meta_q, rxd_sync_q;
  logic [2:0]      rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rda_q, rda_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TxIdle: begin
        if (wr_tx) begin
          tx_state_d = TxStart;
          tx_shift_d = wr_data;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
        end
      end
      TxStart: begin
        if (en_16x) begin
          if (tx_cnt_q == TickLast) begin
            tx_state_d = TxData;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            txd_d      = tx_shift_q[0];
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      TxData: begin
        if (en_16x) begin
          if (tx_cnt_q == TickLast) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_d = TxStop;
              txd_d      = 1'b1;
            end else begin
              tx_bit_d   = tx_bit_q + 1'b1;
              tx_shift_d = {1'b0, tx_shift_q[7:1]};
              txd_d      = tx_shift_q[1];
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      TxStop: begin
        if (en_16x) begin
          if (tx_cnt_q == TickLast) begin
            tx_state_d = TxIdle;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    // A completing byte below overrides this clear, so set wins over rd_rx.
    rda_d      = rd_rx ? 1'b0 : rda_q;
    case (rx_state_q)
      RxIdle: begin
        if (en_16x && !rxd_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (en_16x) begin
          if (rx_cnt_q == TickHalf) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rxd_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxData: begin
        if (en_16x) begin
          if (rx_cnt_q == TickLast) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_d = RxStop;
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxStop: begin
        if (en_16x) begin
          if (rx_cnt_q == TickLast) begin
            rx_cnt_d = '0;
            if (rxd_sync_q) begin
              rx_data_d  = rx_shift_q;
              rda_d      = 1'b1;
              rx_state_d = RxIdle;
            end else begin
              rx_state_d = RxWait;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxWait: begin
        // Framing error: re-arm only once the line has returned high.
        if (rxd_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rda_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
    end
  end

  assign txd     = txd_q;
  assign tbr     = (tx_state_q == TxIdle);
  assign rx_data = rx_data_q;
  assign rda     = rda_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: directed frame scenarios plus randomized loopback
// traffic checked against a frame-level model built from 10-bit {stop, data, start} words.
module tb_uart_transceiver;

  localparam int unsigned OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_16x = 1'b1;
  logic       wr_tx = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_rx = 1'b0;
  logic       txd, tbr, rxd, rda;
  logic [7:0] rx_data;
  logic       loop_en = 1'b1;
  logic       rxd_tb = 1'b1;
  bit         en_rand = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rxd = loop_en ? txd : rxd_tb;

  uart_transceiver #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_16x  (en_16x),
    .wr_tx   (wr_tx),
    .wr_data (wr_data),
    .txd     (txd),
    .tbr     (tbr),
    .rxd     (rxd),
    .rd_rx   (rd_rx),
    .rx_data (rx_data),
    .rda     (rda)
  );

  // Oversample tick: every cycle, or roughly two cycles in three when randomized.
  initial begin
    forever begin
      @(negedge clk);
      en_16x = en_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_tx   = 1'b1;
    @(negedge clk);
    wr_tx   = 1'b0;
  endtask

  task automatic read_pulse;
    rd_rx = 1'b1;
    @(negedge clk);
    rd_rx = 1'b0;
  endtask

  task automatic wait_rda(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rda === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_tbr(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (tbr === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_serial(input logic [7:0] b);
    logic [9:0] f;
    f = frame_of(b);
    for (int i = 0; i < 10; i++) begin
      rxd_tb = f[i];
      repeat (OS) @(negedge clk);
    end
    rxd_tb = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({txd, tbr, rda} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_flags: txd,tbr,rda got %b expected 110", {txd, tbr, rda});
    end
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback_a5;
    bit ok;
    do_reset();
    loop_en = 1'b1;
    write_byte(8'hA5);
    wait_rda(400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL loop_a5_rda: got rda=0 after 400 cycles expected 1");
    end
    n_checks++;
    if (rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL loop_a5_data: got %h expected a5", rx_data);
    end
    read_pulse();
    n_checks++;
    if (rda !== 1'b0 || rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL loop_a5_read: got rda=%b data=%h expected rda=0 data=a5", rda, rx_data);
    end
    wait_tbr(400, ok);
  endtask

  task automatic test_tx_waveform;
    logic [9:0] f;
    int         bad;
    do_reset();
    f = frame_of(8'h3C);
    bad = 0;
    write_byte(8'h3C);
    for (int i = 0; i < 10 * OS; i++) begin
      n_checks++;
      if (txd !== f[i / OS] || tbr !== 1'b0) begin
        n_fail++;
        bad++;
        if (bad <= 8)
          $display("FAIL tx_wave cycle %0d: got txd=%b tbr=%b expected txd=%b tbr=0",
                   i, txd, tbr, f[i / OS]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (tbr !== 1'b1 || txd !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_wave_end: got txd=%b tbr=%b expected txd=1 tbr=1", txd, tbr);
    end
  endtask

  task automatic test_write_ignored_back_to_back;
    bit ok;
    do_reset();
    loop_en = 1'b1;
    write_byte(8'h00);
    repeat (50) @(negedge clk);
    write_byte(8'hFF);
    wait_rda(400, ok);
    n_checks++;
    if (!ok || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL busy_write: got rda=%b data=%h expected rda=1 data=00", rda, rx_data);
    end
    read_pulse();
    wait_tbr(400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL busy_tbr: got tbr=0 after 400 cycles expected 1");
    end
    write_byte(8'h81);
    n_checks++;
    if (txd !== 1'b0 || tbr !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start: got txd=%b tbr=%b expected txd=0 tbr=0", txd, tbr);
    end
    wait_rda(400, ok);
    n_checks++;
    if (!ok || rx_data !== 8'h81) begin
      n_fail++;
      $display("FAIL b2b_data: got rda=%b data=%h expected rda=1 data=81", rda, rx_data);
    end
    read_pulse();
    wait_tbr(400, ok);
  endtask

  task automatic test_glitch;
    bit ok;
    do_reset();
    loop_en = 1'b0;
    rxd_tb  = 1'b1;
    repeat (4) @(negedge clk);
    rxd_tb = 1'b0;
    repeat (4) @(negedge clk);
    rxd_tb = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (rda !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL glitch: got rda=%b data=%h expected rda=0 data=00", rda, rx_data);
    end
    send_serial(8'h5A);
    wait_rda(40, ok);
    n_checks++;
    if (!ok || rx_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL glitch_then_5a: got rda=%b data=%h expected rda=1 data=5a", rda, rx_data);
    end
  endtask

  task automatic test_overrun;
    bit seen;
    do_reset();
    loop_en = 1'b0;
    rxd_tb  = 1'b1;
    repeat (4) @(negedge clk);
    send_serial(8'h11);
    send_serial(8'h22);
    n_checks++;
    if (rda !== 1'b1 || rx_data !== 8'h22) begin
      n_fail++;
      $display("FAIL overrun: got rda=%b data=%h expected rda=1 data=22", rda, rx_data);
    end
    read_pulse();
    n_checks++;
    if (rda !== 1'b0 || rx_data !== 8'h22) begin
      n_fail++;
      $display("FAIL overrun_read: got rda=%b data=%h expected rda=0 data=22", rda, rx_data);
    end
    seen = 1'b0;
    // Hold rd_rx across the completion window; drop it once the set is observed.
    fork
      send_serial(8'h33);
      begin
        repeat (140) @(negedge clk);
        rd_rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (rda === 1'b1) begin
            rd_rx = 1'b0;
            seen  = 1'b1;
            break;
          end
        end
        rd_rx = 1'b0;
      end
    join
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL set_vs_clear: got rda never 1 expected set to win over rd_rx");
    end
    n_checks++;
    if (rda !== 1'b1 || rx_data !== 8'h33) begin
      n_fail++;
      $display("FAIL set_vs_clear_data: got rda=%b data=%h expected rda=1 data=33", rda, rx_data);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit         ok;
    logic [9:0] f;
    do_reset();
    loop_en = 1'b1;
    write_byte(8'h96);
    wait_rda(400, ok);
    wait_tbr(400, ok);
    n_checks++;
    if (rda !== 1'b1 || rx_data !== 8'h96) begin
      n_fail++;
      $display("FAIL pre_reset: got rda=%b data=%h expected rda=1 data=96", rda, rx_data);
    end
    f = frame_of(8'h3A);
    write_byte(8'h3A);
    repeat (55) @(negedge clk);
    n_checks++;
    if (txd !== f[55 / OS] || tbr !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_frame: got txd=%b tbr=%b expected txd=%b tbr=0", txd, tbr, f[55 / OS]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({txd, tbr, rda} !== 3'b110 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got txd,tbr,rda=%b data=%h expected 110 data=00",
               {txd, tbr, rda}, rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write_byte(8'hC3);
    wait_rda(400, ok);
    n_checks++;
    if (!ok || rx_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL post_reset_c3: got rda=%b data=%h expected rda=1 data=c3", rda, rx_data);
    end
    read_pulse();
    wait_tbr(400, ok);
  endtask

  task automatic test_random_loopback;
    logic [7:0] exp_q[$];
    logic [7:0] b, e;
    bit         ok;
    do_reset();
    loop_en = 1'b1;
    en_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      wait_tbr(3000, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_tbr %0d: got tbr=0 expected 1", k);
      end
      write_byte(b);
      exp_q.push_back(b);
      n_checks++;
      if (txd !== 1'b0 || tbr !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_start %0d: got txd=%b tbr=%b expected 0 0", k, txd, tbr);
      end
      wait_rda(3000, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || rx_data !== e) begin
        n_fail++;
        $display("FAIL rand_data %0d: got rda=%b data=%h expected rda=1 data=%h", k, rda,
                 rx_data, e);
      end
      read_pulse();
      n_checks++;
      if (rda !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_read %0d: got rda=%b expected 0", k, rda);
      end
    end
    en_rand = 1'b0;
    wait_tbr(3000, ok);
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_tx_waveform();
    test_write_ignored_back_to_back();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_random_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
